// File: rtl/fifo_chain_if.sv
// fifo_chain_if: producer/consumer bundle for fifo_chain.
//   master : drives push/data_in/pop/err_clr, observes status and read data
//   slave  : the chain itself
// Status: data_out (show-ahead head, 0 when empty), out_valid, in_ready,
// per-stage empty/full, total count, sticky overflow/underflow.
interface fifo_chain_if #(
  parameter int WIDTH       = 8,
  parameter int STAGES      = 2,
  parameter int STAGE_DEPTH = 4,
  parameter int CNT_W       = $clog2(STAGES*STAGE_DEPTH+1)
);
  logic              push;
  logic [WIDTH-1:0]  data_in;
  logic              pop;
  logic              err_clr;
  logic [WIDTH-1:0]  data_out;
  logic              out_valid;
  logic              in_ready;
  logic [STAGES-1:0] empty;
  logic [STAGES-1:0] full;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output push, data_in, pop, err_clr,
    input  data_out, out_valid, in_ready, empty, full, count, overflow, underflow
  );

  modport slave (
    input  push, data_in, pop, err_clr,
    output data_out, out_valid, in_ready, empty, full, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_chain.sv
// fifo_chain: STAGES cascaded circular-buffer FIFOs with automatic forwarding.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-low reset
//   bus   - fifo_chain_if.slave (push/data_in into stage 0, pop from the
//           last stage, err_clr, and all status outputs)
// A word moves from stage i to i+1 whenever stage i is non-empty and stage
// i+1 is non-full, both judged on pre-edge state (no look-through).

// One buffer stage. The parent guarantees i_wr only when not full and
// i_rd only when not empty.
module fifo_chain_stage #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_head,
  output logic             o_empty,
  output logic             o_full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_cnt;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (i_wr) r_wptr <= r_wptr + 1'b1;
      if (i_rd) r_rptr <= r_rptr + 1'b1;
      if (i_wr && !i_rd)      r_cnt <= r_cnt + 1'b1;
      else if (!i_wr && i_rd) r_cnt <= r_cnt - 1'b1;
    end
  end

  // Storage needs no reset: it is only observed through r_cnt/r_rptr.
  always_ff @(posedge clk) begin
    if (i_wr) r_mem[r_wptr] <= i_wdata;
  end

  assign o_head  = r_mem[r_rptr];
  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == CW'(DEPTH));
endmodule

module fifo_chain #(
  parameter int WIDTH       = 8,
  parameter int STAGES      = 2,
  parameter int STAGE_DEPTH = 4,
  parameter int CNT_W       = $clog2(STAGES*STAGE_DEPTH+1)
) (
  input  logic        clk,
  input  logic        rst,
  fifo_chain_if.slave bus
);
  logic [STAGES-1:0]            w_wr, w_rd, w_empty, w_full;
  logic [STAGES-1:0][WIDTH-1:0] w_wdata, w_head;
  logic                         w_acc_push, w_acc_pop;
  logic [CNT_W-1:0]             r_count;
  logic                         r_ovf, r_udf;

  assign w_acc_push = bus.push && !w_full[0];
  assign w_acc_pop  = bus.pop  && !w_empty[STAGES-1];

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    if (g == 0) begin : g_in
      assign w_wr[g]    = w_acc_push;
      assign w_wdata[g] = bus.data_in;
    end else begin : g_fwd_in
      assign w_wr[g]    = !w_empty[g-1] && !w_full[g];
      assign w_wdata[g] = w_head[g-1];
    end

    if (g == STAGES-1) begin : g_out
      assign w_rd[g] = w_acc_pop;
    end else begin : g_fwd_out
      assign w_rd[g] = !w_empty[g] && !w_full[g+1];
    end

    fifo_chain_stage #(.WIDTH(WIDTH), .DEPTH(STAGE_DEPTH)) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_wr    (w_wr[g]),
      .i_wdata (w_wdata[g]),
      .i_rd    (w_rd[g]),
      .o_head  (w_head[g]),
      .o_empty (w_empty[g]),
      .o_full  (w_full[g])
    );
  end

  // Forwarding is internal, so only the chain ends move the total.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (w_acc_push && !w_acc_pop) begin
      r_count <= r_count + 1'b1;
    end else if (!w_acc_push && w_acc_pop) begin
      r_count <= r_count - 1'b1;
    end
  end

  // A fresh error beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (bus.push && w_full[0])               r_ovf <= 1'b1;
      else if (bus.err_clr)                    r_ovf <= 1'b0;
      if (bus.pop && w_empty[STAGES-1])        r_udf <= 1'b1;
      else if (bus.err_clr)                    r_udf <= 1'b0;
    end
  end

  assign bus.out_valid = !w_empty[STAGES-1];
  assign bus.data_out  = bus.out_valid ? w_head[STAGES-1] : '0;
  assign bus.in_ready  = !w_full[0];
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;
  assign bus.count     = r_count;
  assign bus.overflow  = r_ovf;
  assign bus.underflow = r_udf;
endmodule

// File: tb/tb_fifo_chain.sv
// tb_fifo_chain: directed + random checks of two fifo_chain builds
// (2x4 and 3x2) against a queue-per-stage reference model.
module tb_fifo_chain;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_chain_if #(.WIDTH(8), .STAGES(2), .STAGE_DEPTH(4)) a_if();
  fifo_chain_if #(.WIDTH(8), .STAGES(3), .STAGE_DEPTH(2)) b_if();

  fifo_chain #(.WIDTH(8), .STAGES(2), .STAGE_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .bus(a_if));
  fifo_chain #(.WIDTH(8), .STAGES(3), .STAGE_DEPTH(2)) dut_b (
    .clk(clk), .rst(rst), .bus(b_if));

  int n_tests = 0;
  int n_fail  = 0;
  bit sel     = 1'b0;   // 0 drives/checks dut_a, 1 dut_b

  // Reference model: one queue per stage, plus sticky flags.
  int mq[3][$];
  int mS = 2, mD = 4;
  bit mov = 1'b0, muf = 1'b0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 3; i++) mq[i].delete();
    mov = 1'b0;
    muf = 1'b0;
  endtask

  task automatic m_step(bit p, int d, bit po, bit clr);
    bit ap, apo;
    bit f[3];
    ap  = p  && (mq[0].size() < mD);
    apo = po && (mq[mS-1].size() > 0);
    for (int i = 0; i < mS-1; i++)
      f[i] = (mq[i].size() > 0) && (mq[i+1].size() < mD);
    if (apo) void'(mq[mS-1].pop_front());
    for (int i = mS-2; i >= 0; i--) begin
      if (f[i]) begin
        int w;
        w = mq[i].pop_front();
        mq[i+1].push_back(w);
      end
    end
    if (ap) mq[0].push_back(d);
    if (p && !ap) mov = 1'b1; else if (clr) mov = 1'b0;
    if (po && !apo) muf = 1'b1; else if (clr) muf = 1'b0;
  endtask

  task automatic mcheck();
    int cnt, e, f, hd;
    logic [31:0] o_cnt, o_e, o_f, o_v, o_d, o_r, o_ov, o_uf;
    cnt = 0; e = 0; f = 0;
    for (int i = 0; i < mS; i++) begin
      cnt += mq[i].size();
      if (mq[i].size() == 0)  e |= (1 << i);
      if (mq[i].size() == mD) f |= (1 << i);
    end
    hd = (mq[mS-1].size() > 0) ? mq[mS-1][0] : 0;
    o_cnt = sel ? 32'(b_if.count)     : 32'(a_if.count);
    o_e   = sel ? 32'(b_if.empty)     : 32'(a_if.empty);
    o_f   = sel ? 32'(b_if.full)      : 32'(a_if.full);
    o_v   = sel ? 32'(b_if.out_valid) : 32'(a_if.out_valid);
    o_d   = sel ? 32'(b_if.data_out)  : 32'(a_if.data_out);
    o_r   = sel ? 32'(b_if.in_ready)  : 32'(a_if.in_ready);
    o_ov  = sel ? 32'(b_if.overflow)  : 32'(a_if.overflow);
    o_uf  = sel ? 32'(b_if.underflow) : 32'(a_if.underflow);
    chk("m_count",     o_cnt, 32'(cnt));
    chk("m_empty",     o_e,   32'(e));
    chk("m_full",      o_f,   32'(f));
    chk("m_out_valid", o_v,   32'(cnt != 0 && mq[mS-1].size() > 0));
    chk("m_data_out",  o_d,   32'(hd));
    chk("m_in_ready",  o_r,   32'(mq[0].size() < mD));
    chk("m_overflow",  o_ov,  32'(mov));
    chk("m_underflow", o_uf,  32'(muf));
  endtask

  task automatic drive(bit p, logic [7:0] d, bit po, bit clr);
    if (!sel) begin
      a_if.push = p; a_if.data_in = d; a_if.pop = po; a_if.err_clr = clr;
    end else begin
      b_if.push = p; b_if.data_in = d; b_if.pop = po; b_if.err_clr = clr;
    end
  endtask

  // One clock: drive, take the edge, advance the model, check after settle.
  task automatic step(bit p, logic [7:0] d, bit po, bit clr);
    drive(p, d, po, clr);
    @(posedge clk);
    m_step(p, int'(d), po, clr);
    #1;
    mcheck();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_a(string tag);
    chk({tag, "_empty"}, 32'(a_if.empty),     32'h3);
    chk({tag, "_full"},  32'(a_if.full),      32'h0);
    chk({tag, "_count"}, 32'(a_if.count),     32'h0);
    chk({tag, "_valid"}, 32'(a_if.out_valid), 32'h0);
    chk({tag, "_ready"}, 32'(a_if.in_ready),  32'h1);
    chk({tag, "_data"},  32'(a_if.data_out),  32'h0);
    chk({tag, "_ovf"},   32'(a_if.overflow),  32'h0);
    chk({tag, "_udf"},   32'(a_if.underflow), 32'h0);
  endtask

  initial begin
    int got;
    a_if.push = 0; a_if.data_in = 0; a_if.pop = 0; a_if.err_clr = 0;
    b_if.push = 0; b_if.data_in = 0; b_if.pop = 0; b_if.err_clr = 0;

    // Reset held for 3 cycles with random push/pop.
    for (int k = 0; k < 3; k++) begin
      a_if.push = 1'($urandom_range(0, 1)); a_if.pop = 1'($urandom_range(0, 1));
      a_if.data_in = 8'($urandom);
      b_if.push = 1'($urandom_range(0, 1)); b_if.pop = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk_reset_a("rst");
      chk("rst_b_empty", 32'(b_if.empty), 32'h7);
      chk("rst_b_count", 32'(b_if.count), 32'h0);
    end
    a_if.push = 0; a_if.pop = 0; b_if.push = 0; b_if.pop = 0;
    m_reset();
    rst = 1'b1;

    // Single word: visible one edge after the push, then popped.
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("single_valid", 32'(a_if.out_valid), 32'h1);
    chk("single_data",  32'(a_if.data_out),  32'hA5);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("single_count", 32'(a_if.count),     32'h0);
    chk("single_empty", 32'(a_if.out_valid), 32'h0);

    // Fill, overflow, drain in order.
    for (int i = 0; i < 8; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("fill_count", 32'(a_if.count),    32'd8);
    chk("fill_full",  32'(a_if.full),     32'h3);
    chk("fill_ready", 32'(a_if.in_ready), 32'h0);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("ovf_flag",  32'(a_if.overflow), 32'h1);
    chk("ovf_count", 32'(a_if.count),    32'd8);
    got = 0;
    for (int k = 0; k < 40 && got < 8; k++) begin
      if (a_if.out_valid) begin
        chk("drain_data", 32'(a_if.data_out), 32'(got));
        step(1'b0, 8'h00, 1'b1, 1'b0);
        got++;
      end else begin
        step(1'b0, 8'h00, 1'b0, 1'b0);
      end
    end
    chk("drain_words", 32'(got), 32'd8);
    chk("drain_empty", 32'(a_if.out_valid), 32'h0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr", 32'(a_if.overflow), 32'h0);

    // Underflow, clear, and error-beats-clear.
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("udf_flag",  32'(a_if.underflow), 32'h1);
    chk("udf_count", 32'(a_if.count),     32'h0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("udf_clr", 32'(a_if.underflow), 32'h0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("udf_wins", 32'(a_if.underflow), 32'h1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Async reset mid-stream with 5 words held.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    chk("ar_count", 32'(a_if.count), 32'd5);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_a("ar");
    m_reset();
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("ar_sole_data",  32'(a_if.data_out), 32'h3C);
    chk("ar_sole_count", 32'(a_if.count),    32'h1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("ar_sole_gone", 32'(a_if.out_valid), 32'h0);

    // Random traffic against the model.
    for (int k = 0; k < 300; k++)
      step(1'($urandom_range(0, 9) < 7), 8'($urandom),
           1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 19) == 0));

    // 3x2 build: prefill, settle, then stream one-in/one-out.
    sel = 1'b1; mS = 3; mD = 2; m_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 50; k++) begin
      chk("stream_data", 32'(b_if.data_out), 32'(k));
      step(1'b1, 8'(k + 3), 1'b1, 1'b0);
      chk("stream_count", 32'(b_if.count), 32'd3);
    end
    chk("stream_ovf", 32'(b_if.overflow),  32'h0);
    chk("stream_udf", 32'(b_if.underflow), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_chain.md
# fifo_chain

Parametrised cascade of `STAGES` identical FIFO stages with automatic inter-stage forwarding, a total-occupancy counter and sticky overflow/underflow error flags. It generalises the two-FIFO composition used in the formal top. Forwarding between stages is internal rather than driven by external pop strobes. Protocol violations are recorded in flags instead of being excluded by environment constraints. The block sits between a producer and a consumer (and alongside the scoreboard in formal tops) as an ordered, in-order buffer of `STAGES*STAGE_DEPTH` words.

## Interface
- `WIDTH`, 8, data word width in bits
- `STAGES`, 2, number of cascaded stages, ≥1
- `STAGE_DEPTH`, 4, words per stage, power of two, ≥2
- `CNT_W`, `$clog2(STAGES*STAGE_DEPTH+1)`, width of `count`
- `clk`  input  1  single clock; all state updates on its rising edge
- `rst`  input  1  asynchronous, active-low reset
- `push`  input  1  write request for `data_in` into stage 0
- `data_in`  input  WIDTH  write data
- `pop`  input  1  read request from the last stage
- `err_clr`  input  1  synchronous clear of `overflow` and `underflow`
- `data_out`  output  WIDTH  head of the last stage (show-ahead); 0 when `out_valid`=0
- `out_valid`  output  1  equals `!empty[STAGES-1]`
- `in_ready`  output  1  equals `!full[0]`
- `empty`  output  STAGES  per-stage empty flags
- `full`  output  STAGES  per-stage full flags
- `count`  output  CNT_W  total words held across all stages
- `overflow`  output  1  sticky: a push was attempted while `full[0]`
- `underflow`  output  1  sticky: a pop was attempted while `empty[STAGES-1]`

## Operation
- Each stage is a circular buffer with read/write pointers and its own occupancy counter. Pointers wrap modulo `STAGE_DEPTH`.
- Accepted push: `push && !full[0]`. `data_in` is written to stage 0.
- Accepted pop: `pop && !empty[STAGES-1]`. The last-stage head advances.
- Forwarding at boundary i→i+1 happens every cycle when `!empty[i] && !full[i+1]`, with both flags sampled before the edge. There is no look-through: a same-cycle pop from stage i+1 does not free space for a forward.
- A stage may receive and send in the same cycle; its occupancy is then unchanged.
- Rejected push: the word is dropped, `overflow` is set to 1, and no other state changes.
- Rejected pop: `underflow` is set to 1 and no other state changes.
- `count` changes as follows:
  - +1 on an accepted push.
  - −1 on an accepted pop.
  - Unchanged when both occur, and unchanged by forwarding.
  - Always equals the sum of stage occupancies and never exceeds `STAGES*STAGE_DEPTH`.
- When `err_clr` and a new error occur in the same cycle, the new error wins and its flag reads 1.
- Ordering is strict FIFO end to end.

## Timing
- Reset (`rst`=0) clears all pointers and counters immediately, without waiting for a clock edge. While reset is held:
  - `empty`=all 1s, `full`=0, `count`=0, `out_valid`=0, `in_ready`=1, `data_out`=0, `overflow`=0, `underflow`=0.
- Reset asserted mid-operation discards all contents. Deassertion is synchronised by the integrator; the first edge after release may accept a push.
- Latency: a word pushed at edge t into an empty chain reaches the last stage at edge t+STAGES−1. `out_valid` and `data_out` are visible after that edge. For `STAGES`=1, the word is visible after edge t.
- Flags, `count` and the error bits are registered-state derived and update on the same edge as the event that causes them.
- Steady-state throughput is one word per cycle in and out with no bubbles once every stage is non-full and non-empty.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles with random `push`/`pop`. Required: `empty`=2'b11, `full`=2'b00, `count`=0, `out_valid`=0, both error flags 0.
- **Single word:** push 0xA5 at edge t.
  - Required: `out_valid`=1 and `data_out`=0xA5 after edge t+1.
  - Pop at t+2; required: `count`=0 and `out_valid`=0 after that edge.
- **Fill and overflow:** push 0x00..0x07 on consecutive cycles with no pops, then idle 2 cycles.
  - Required: `count`=8, `full`=2'b11, `in_ready`=0.
  - A 9th push of 0xFF: required `overflow`=1 and `count`=8.
  - Draining must return 0x00..0x07 in order, with 0xFF never appearing.
- **Underflow and clear:** pop on an empty chain. Required: `underflow`=1, `count`=0, no pointer movement. Pulse `err_clr`; required: `underflow`=0 on the next cycle.
- **Async reset mid-stream:** with `count`=5, drive `rst` low between clock edges. Required: all outputs at their reset values before the next rising edge. After release, push 0x3C; it must arrive as the sole word.
- **Streaming and parameter sweep:** with `STAGES`=3 and `STAGE_DEPTH`=2, prefill 3 words, then push and pop every cycle for 50 cycles with an incrementing pattern. Required: `count` constant at 3, output sequence equals the input sequence delayed by 3 words, no error flags.
